// File: rtl/decode_queue_stage.sv
// Byte-queue decode stage: buffers fetch beats, aligns 1-5 byte instructions at
// the queue head and emits one registered uop per cycle with valid/ready handshake.
module decode_queue_stage #(
    parameter int unsigned FETCH_BYTES = 8,
    parameter int unsigned QUEUE_BYTES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_valid_i,
    input  logic [8*FETCH_BYTES-1:0] fetch_bytes_i,
    output logic                     fetch_ready_o,
    input  logic                     redirect_valid_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_pc_o,
    output logic [31:0]              out_imm_o,
    output logic [2:0]               out_src1_idx_o,
    output logic [2:0]               out_src2_idx_o,
    output logic [6:0]               out_ctrl_o,
    output logic [2:0]               out_length_o,
    output logic                     out_illegal_o
);
    localparam int unsigned PTR_W  = $clog2(QUEUE_BYTES);
    localparam int unsigned CNT_W  = $clog2(QUEUE_BYTES + 1);
    localparam int unsigned HEAD_N = 5;

    typedef enum logic [1:0] {S_RUN, S_WAIT_REDIRECT, S_HALTED} state_e;

    logic [7:0]       mem_q [QUEUE_BYTES];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_q, pc_d;
    state_e           state_q, state_d;

    logic        out_valid_q, out_valid_d, out_illegal_q, out_illegal_d;
    logic [31:0] out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [2:0]  out_src1_q, out_src1_d, out_src2_q, out_src2_d, out_len_q, out_len_d;
    logic [6:0]  out_ctrl_q, out_ctrl_d;

    logic [7:0]  hb [HEAD_N];
    logic [2:0]  dec_len, dec_src1, dec_src2;
    logic [31:0] dec_imm;
    logic [6:0]  dec_ctrl;
    logic        dec_ill, head_complete, push, load;

    assign fetch_ready_o = !redirect_valid_i && (count_q <= CNT_W'(QUEUE_BYTES - FETCH_BYTES));
    assign push          = fetch_valid_i && fetch_ready_o;

    // Head decode; ctrl = {src2mux, op, read1, read2, we, is_jmp, is_halt}
    always_comb begin
        for (int unsigned k = 0; k < HEAD_N; k++) begin
            hb[k] = mem_q[PTR_W'(head_q + PTR_W'(k))];
        end
        dec_len  = 3'd1;
        dec_imm  = 32'h0;
        dec_src1 = 3'd0;
        dec_src2 = 3'd0;
        dec_ctrl = 7'b0;
        dec_ill  = 1'b0;
        casez (hb[0])
            8'h01: begin
                dec_len  = 3'd2;
                dec_src1 = hb[1][2:0];
                dec_src2 = hb[1][5:3];
                dec_ctrl = 7'b0111100;
            end
            8'h05: begin
                dec_len  = 3'd5;
                dec_imm  = {hb[4], hb[3], hb[2], hb[1]};
                dec_ctrl = 7'b1110100;
            end
            8'h83: begin
                dec_len  = 3'd3;
                dec_src1 = hb[1][2:0];
                dec_imm  = {{24{hb[2][7]}}, hb[2]};
                dec_ctrl = 7'b1110100;
            end
            8'hE9: begin
                dec_len  = 3'd5;
                dec_imm  = {hb[4], hb[3], hb[2], hb[1]};
                dec_ctrl = 7'b0000010;
            end
            8'b1011_1???: begin
                dec_len  = 3'd5;
                dec_src1 = hb[0][2:0];
                dec_imm  = {hb[4], hb[3], hb[2], hb[1]};
                dec_ctrl = 7'b1000100;
            end
            8'hF4: dec_ctrl = 7'b0000001;
            default: dec_ill = 1'b1;
        endcase
    end

    assign head_complete = (count_q >= CNT_W'(1)) && (count_q >= CNT_W'(dec_len));
    assign load = (state_q == S_RUN) && head_complete && (!out_valid_q || out_ready_i)
                  && !redirect_valid_i;

    // Next-state: redirect flushes everything, otherwise push/pop/handshake
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        pc_d          = pc_q;
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_imm_d     = out_imm_q;
        out_src1_d    = out_src1_q;
        out_src2_d    = out_src2_q;
        out_ctrl_d    = out_ctrl_q;
        out_len_d     = out_len_q;
        out_illegal_d = out_illegal_q;
        if (redirect_valid_i) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            pc_d        = redirect_pc_i;
            out_valid_d = 1'b0;
            state_d     = S_RUN;
        end else begin
            if (push) begin
                tail_d = PTR_W'(tail_q + PTR_W'(FETCH_BYTES));
            end
            if (load) begin
                out_valid_d   = 1'b1;
                out_pc_d      = pc_q;
                out_imm_d     = dec_imm;
                out_src1_d    = dec_src1;
                out_src2_d    = dec_src2;
                out_ctrl_d    = dec_ctrl;
                out_len_d     = dec_len;
                out_illegal_d = dec_ill;
                head_d        = PTR_W'(head_q + PTR_W'(dec_len));
                pc_d          = pc_q + 32'(dec_len);
                if (dec_ctrl[1]) begin
                    state_d = S_WAIT_REDIRECT;
                end else if (dec_ctrl[0]) begin
                    state_d = S_HALTED;
                end
            end else if (out_valid_q && out_ready_i) begin
                out_valid_d = 1'b0;
            end
            count_d = count_q + (push ? CNT_W'(FETCH_BYTES) : CNT_W'(0))
                              - (load ? CNT_W'(dec_len) : CNT_W'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            pc_q          <= RESET_PC;
            state_q       <= S_RUN;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'h0;
            out_imm_q     <= 32'h0;
            out_src1_q    <= 3'd0;
            out_src2_q    <= 3'd0;
            out_ctrl_q    <= 7'b0;
            out_len_q     <= 3'd0;
            out_illegal_q <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            pc_q          <= pc_d;
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_imm_q     <= out_imm_d;
            out_src1_q    <= out_src1_d;
            out_src2_q    <= out_src2_d;
            out_ctrl_q    <= out_ctrl_d;
            out_len_q     <= out_len_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // Byte storage carries no reset; only bytes below count are ever consumed
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
                mem_q[PTR_W'(tail_q + PTR_W'(k))] <= fetch_bytes_i[8*k +: 8];
            end
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_pc_o       = out_pc_q;
    assign out_imm_o      = out_imm_q;
    assign out_src1_idx_o = out_src1_q;
    assign out_src2_idx_o = out_src2_q;
    assign out_ctrl_o     = out_ctrl_q;
    assign out_length_o   = out_len_q;
    assign out_illegal_o  = out_illegal_q;
endmodule

// File: tb/tb_decode_queue_stage.sv
// Bench for decode_queue_stage: byte-queue reference model checked every cycle,
// plus directed scenarios pinned with hand-computed uop values.
module tb_decode_queue_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [63:0] fetch_bytes;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_src1_idx;
    logic [2:0]  out_src2_idx;
    logic [6:0]  out_ctrl;
    logic [2:0]  out_length;
    logic        out_illegal;

    always #5 clk = ~clk;

    decode_queue_stage #(.FETCH_BYTES(8), .QUEUE_BYTES(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid_i(fetch_valid), .fetch_bytes_i(fetch_bytes), .fetch_ready_o(fetch_ready),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_imm_o(out_imm),
        .out_src1_idx_o(out_src1_idx), .out_src2_idx_o(out_src2_idx),
        .out_ctrl_o(out_ctrl), .out_length_o(out_length), .out_illegal_o(out_illegal)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [6:0]  ctrl;
        logic [2:0]  len;
        logic        ill;
    } uop_t;

    logic [7:0]  m_q[$];
    logic [31:0] m_pc;
    int          m_state;  // 0 running, 1 waiting for redirect, 2 halted
    bit          m_ov;
    uop_t        m_uop;
    bit          mp_push, mp_load;
    int          mp_len;

    function automatic logic [7:0] mb(input int k);
        return (k < m_q.size()) ? m_q[k] : 8'h00;
    endfunction

    function automatic int op_len(input logic [7:0] op);
        if (op == 8'h01) return 2;
        if (op == 8'h83) return 3;
        if (op == 8'h05 || op == 8'hE9 || (op >= 8'hB8 && op <= 8'hBF)) return 5;
        return 1;
    endfunction

    function automatic uop_t m_decode();
        uop_t u;
        logic [7:0] b0;
        logic src2mux, op, rd1, rd2, we, jmp, hlt;
        b0 = mb(0);
        u = '0;
        {src2mux, op, rd1, rd2, we, jmp, hlt} = 7'b0;
        u.pc  = m_pc;
        u.len = 3'(op_len(b0));
        if (b0 == 8'h01) begin
            u.s1 = mb(1) & 8'h07;
            u.s2 = (mb(1) >> 3) & 8'h07;
            {op, rd1, rd2, we} = 4'b1111;
        end else if (b0 == 8'h05) begin
            u.imm = {mb(4), mb(3), mb(2), mb(1)};
            {src2mux, op, rd1, we} = 4'b1111;
        end else if (b0 == 8'h83) begin
            u.s1  = mb(1) & 8'h07;
            u.imm = mb(2)[7] ? (32'hFFFFFF00 | 32'(mb(2))) : 32'(mb(2));
            {src2mux, op, rd1, we} = 4'b1111;
        end else if (b0 == 8'hE9) begin
            u.imm = {mb(4), mb(3), mb(2), mb(1)};
            jmp = 1'b1;
        end else if (b0 >= 8'hB8 && b0 <= 8'hBF) begin
            u.s1  = 3'(b0 - 8'hB8);
            u.imm = {mb(4), mb(3), mb(2), mb(1)};
            {src2mux, we} = 2'b11;
        end else if (b0 == 8'hF4) begin
            hlt = 1'b1;
        end else begin
            u.ill = 1'b1;
        end
        u.ctrl = {src2mux, op, rd1, rd2, we, jmp, hlt};
        return u;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc    = 32'h0;
            m_state = 0;
            m_ov    = 0;
            m_uop   = '0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc    = redirect_pc;
            m_state = 0;
            m_ov    = 0;
        end else begin
            mp_push = fetch_valid && (16 - m_q.size() >= 8);
            mp_len  = op_len(mb(0));
            mp_load = (m_state == 0) && (m_q.size() >= 1) && (m_q.size() >= mp_len)
                      && (!m_ov || out_ready);
            if (mp_load) begin
                m_uop = m_decode();
                m_ov  = 1;
                if (mb(0) == 8'hE9) m_state = 1;
                else if (mb(0) == 8'hF4) m_state = 2;
                for (int i = 0; i < mp_len; i++) void'(m_q.pop_front());
                m_pc = m_pc + 32'(mp_len);
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (mp_push) begin
                for (int i = 0; i < 8; i++) m_q.push_back(fetch_bytes[8*i +: 8]);
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("fetch_ready", 32'(fetch_ready), 32'(!redirect_valid && (16 - m_q.size() >= 8)));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("out_pc", out_pc, m_uop.pc);
                chk("out_imm", out_imm, m_uop.imm);
                chk("out_src1", 32'(out_src1_idx), 32'(m_uop.s1));
                chk("out_src2", 32'(out_src2_idx), 32'(m_uop.s2));
                chk("out_ctrl", 32'(out_ctrl), 32'(m_uop.ctrl));
                chk("out_length", 32'(out_length), 32'(m_uop.len));
                chk("out_illegal", 32'(out_illegal), 32'(m_uop.ill));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] beat(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic push_beat(input logic [63:0] b);
        bit ok;
        ok          = 0;
        fetch_valid = 1'b1;
        fetch_bytes = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = fetch_ready;
            tick();
        end
        fetch_valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic expect_uop(input string nm, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [2:0] s1, input logic [2:0] s2, input logic [6:0] ctrl,
                              input logic [2:0] len, input logic ill);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
            if (!seen) tick();
        end
        chk({nm, ".seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({nm, ".pc"}, out_pc, pc);
            chk({nm, ".imm"}, out_imm, imm);
            chk({nm, ".src1"}, 32'(out_src1_idx), 32'(s1));
            chk({nm, ".src2"}, 32'(out_src2_idx), 32'(s2));
            chk({nm, ".ctrl"}, 32'(out_ctrl), 32'(ctrl));
            chk({nm, ".len"}, 32'(out_length), 32'(len));
            chk({nm, ".illegal"}, 32'(out_illegal), 32'(ill));
        end
        tick();
    endtask

    task automatic idle_check(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(nm, 32'(out_valid), 32'd0);
            tick();
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, ".valid"}, 32'(out_valid), 32'd0);
        chk({nm, ".pc"}, out_pc, 32'h0);
        chk({nm, ".imm"}, out_imm, 32'h0);
        chk({nm, ".src"}, 32'({out_src1_idx, out_src2_idx}), 32'd0);
        chk({nm, ".ctrl"}, 32'(out_ctrl), 32'd0);
        chk({nm, ".len"}, 32'(out_length), 32'd0);
        chk({nm, ".illegal"}, 32'(out_illegal), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; fetch_valid = 1'b0; fetch_bytes = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick();
        tick();
        check_zero_outputs("reset");
        chk("reset.fetch_ready", 32'(fetch_ready), 32'd1);
        chk_en = 1;
        rst_n  = 1'b1;

        // MOV / ADD / HLT straight-line block
        out_ready = 1'b1;
        push_beat(beat(8'hB8, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC8, 8'hF4));
        expect_uop("movi", 32'h0, 32'h5, 3'd0, 3'd0, 7'b1000100, 3'd5, 1'b0);
        expect_uop("add",  32'h5, 32'h0, 3'd0, 3'd1, 7'b0111100, 3'd2, 1'b0);
        expect_uop("hlt",  32'h7, 32'h0, 3'd0, 3'd0, 7'b0000001, 3'd1, 1'b0);
        idle_check("halted_idle", 3);
        push_beat(beat(8'h01, 8'hC8, 8'h01, 8'hC8, 8'h01, 8'hC8, 8'h01, 8'hC8));
        idle_check("halted_push_idle", 3);

        // Split instructions and head wrap across the 16-byte boundary
        do_redirect(32'h200);
        fork
            begin
                push_beat(beat(8'h01, 8'hC8, 8'h83, 8'hC1, 8'h05, 8'h05, 8'h11, 8'h22));
                repeat (4) tick();
                push_beat(beat(8'h33, 8'h44, 8'h01, 8'hC8, 8'h83, 8'hC1, 8'h80, 8'h05));
                push_beat(beat(8'h78, 8'h56, 8'h34, 8'h12, 8'hF4, 8'h00, 8'h00, 8'h00));
            end
            begin
                expect_uop("s_add1", 32'h200, 32'h0, 3'd0, 3'd1, 7'b0111100, 3'd2, 1'b0);
                expect_uop("s_addi", 32'h202, 32'h5, 3'd1, 3'd0, 7'b1110100, 3'd3, 1'b0);
                expect_uop("s_split", 32'h205, 32'h44332211, 3'd0, 3'd0, 7'b1110100, 3'd5, 1'b0);
                expect_uop("s_add2", 32'h20A, 32'h0, 3'd0, 3'd1, 7'b0111100, 3'd2, 1'b0);
                expect_uop("s_sext", 32'h20C, 32'hFFFFFF80, 3'd1, 3'd0, 7'b1110100, 3'd3, 1'b0);
                expect_uop("s_wrap", 32'h20F, 32'h12345678, 3'd0, 3'd0, 7'b1110100, 3'd5, 1'b0);
                expect_uop("s_hlt", 32'h214, 32'h0, 3'd0, 3'd0, 7'b0000001, 3'd1, 1'b0);
            end
        join

        // Backpressure holds the uop stable
        do_redirect(32'h300);
        out_ready = 1'b0;
        push_beat(beat(8'h83, 8'hC1, 8'hFF, 8'hF4, 8'h00, 8'h00, 8'h00, 8'h00));
        expect_uop("bp", 32'h300, 32'hFFFFFFFF, 3'd1, 3'd0, 7'b1110100, 3'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold.valid", 32'(out_valid), 32'd1);
            chk("bp_hold.imm", out_imm, 32'hFFFFFFFF);
            chk("bp_hold.pc", out_pc, 32'h300);
            chk("bp_hold.src1", 32'(out_src1_idx), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        expect_uop("bp_hlt", 32'h303, 32'h0, 3'd0, 3'd0, 7'b0000001, 3'd1, 1'b0);

        // JMP stalls decode until a redirect
        do_redirect(32'h400);
        push_beat(beat(8'hE9, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC8, 8'hF4));
        expect_uop("jmp", 32'h400, 32'h10, 3'd0, 3'd0, 7'b0000010, 3'd5, 1'b0);
        idle_check("jmp_wait_idle", 3);
        do_redirect(32'h100);
        push_beat(beat(8'h01, 8'hD1, 8'hF4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        expect_uop("post_jmp_add", 32'h100, 32'h0, 3'd1, 3'd2, 7'b0111100, 3'd2, 1'b0);
        expect_uop("post_jmp_hlt", 32'h102, 32'h0, 3'd0, 3'd0, 7'b0000001, 3'd1, 1'b0);

        // Full queue, then redirect colliding with a fetch beat
        do_redirect(32'h500);
        out_ready = 1'b0;
        push_beat(beat(8'h01, 8'hC8, 8'h01, 8'hC8, 8'h01, 8'hC8, 8'h01, 8'hC8));
        push_beat(beat(8'h01, 8'hC8, 8'h01, 8'hC8, 8'h01, 8'hC8, 8'h01, 8'hC8));
        fetch_valid = 1'b1;
        fetch_bytes = beat(8'hF4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("full.fetch_ready", 32'(fetch_ready), 32'd0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h600;
        tick();
        redirect_valid = 1'b0;
        fetch_valid    = 1'b0;
        @(negedge clk);
        chk("redir_drop.valid", 32'(out_valid), 32'd0);
        chk("redir_drop.fetch_ready", 32'(fetch_ready), 32'd1);
        tick();
        idle_check("redir_drop_idle", 3);

        // Illegal opcode, then reset during a stall
        do_redirect(32'h700);
        out_ready = 1'b1;
        push_beat(beat(8'h0F, 8'hF4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        expect_uop("illegal", 32'h700, 32'h0, 3'd0, 3'd0, 7'b0000000, 3'd1, 1'b1);
        expect_uop("ill_hlt", 32'h701, 32'h0, 3'd0, 3'd0, 7'b0000001, 3'd1, 1'b0);
        do_redirect(32'h800);
        out_ready = 1'b0;
        push_beat(beat(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F));
        expect_uop("stall_ill", 32'h800, 32'h0, 3'd0, 3'd0, 7'b0000000, 3'd1, 1'b1);
        rst_n = 1'b0;
        tick();
        check_zero_outputs("midstall_reset");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push_beat(beat(8'hB9, 8'h78, 8'h56, 8'h34, 8'h12, 8'hF4, 8'h00, 8'h00));
        expect_uop("rst_movi", 32'h0, 32'h12345678, 3'd1, 3'd0, 7'b1000100, 3'd5, 1'b0);
        expect_uop("rst_hlt", 32'h5, 32'h0, 3'd0, 3'd0, 7'b0000001, 3'd1, 1'b0);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
